// File: rtl/operand_entry_pkg.sv
// Shared types for the operand entry block: FSM state encoding and operand width.
package operand_entry_pkg;

  localparam int OPW = 4;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_READY   = 2'b10
  } state_e;

  // True when the stored A operand is below the value now on the switches.
  function automatic logic a_below(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    return (a < b);
  endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Board-side bundle for operand_entry: switch/button inputs and registered operand outputs.
interface operand_entry_if;
  import operand_entry_pkg::*;

  logic [OPW-1:0] sw;
  logic           op_sw;
  logic           btn;
  logic [OPW-1:0] out_a;
  logic [OPW-1:0] out_b;
  logic           out_op;
  logic           out_valid;
  logic           neg;
  logic [1:0]     state_led;

  modport master (
    output sw, op_sw, btn,
    input  out_a, out_b, out_op, out_valid, neg, state_led
  );

  modport slave (
    input  sw, op_sw, btn,
    output out_a, out_b, out_op, out_valid, neg, state_led
  );

endinterface

// File: rtl/operand_entry_btn_debounce.sv
// Load-button conditioning: 2-flop synchronizer, consecutive-cycle debounce and one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          armed_q, armed_d;
  logic [1:0]    warm_q, warm_d;

  // The synchronizer holds reset zeros for two edges after release; arming waits
  // for a genuine low so a button held through reset never yields a press.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    warm_d  = {warm_q[0], 1'b1};
    if (warm_q[1] && !sync2_q) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
        press_d = sync2_q & armed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      press_q <= 1'b0;
      armed_q <= 1'b0;
      warm_q  <= 2'b00;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      armed_q <= armed_d;
      warm_q  <= warm_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/operand_entry.sv
// Operand entry FSM: each debounced press loads A, then B/op, then releases the set.
// Optional OPERAND_ENTRY_ORDER_EN swaps operands for subtraction so the result is non-negative.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic          clk_in,
  input  logic          rst_n,
  operand_entry_if.slave bus
);

  logic           press_s;
  logic           swap_s;
  state_e         state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d;
  logic           op_q, op_d;
  logic           valid_q, valid_d;
  logic           neg_q, neg_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .btn_i   (bus.btn),
    .press_o (press_s)
  );

`ifdef OPERAND_ENTRY_ORDER_EN
  assign swap_s = bus.op_sw & a_below(a_q, bus.sw);
`else
  assign swap_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENTER_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to ENTER_A.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTER_A: if (press_s) state_d = ST_ENTER_B; else state_d = ST_ENTER_A;
      ST_ENTER_B: if (press_s) state_d = ST_READY;   else state_d = ST_ENTER_B;
      ST_READY:   if (press_s) state_d = ST_ENTER_A; else state_d = ST_READY;
      default:    state_d = ST_ENTER_A;
    endcase
  end

  // Operand capture decisions per state.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    neg_d   = neg_q;
    case (state_q)
      ST_ENTER_A: begin
        if (press_s) begin
          a_d     = bus.sw;
          valid_d = 1'b0;
          neg_d   = 1'b0;
        end else begin
          a_d = a_q;
        end
      end
      ST_ENTER_B: begin
        if (press_s) begin
          if (swap_s) begin
            a_d = bus.sw;
            b_d = a_q;
          end else begin
            b_d = bus.sw;
          end
          op_d    = bus.op_sw;
          valid_d = 1'b1;
          neg_d   = swap_s;
        end else begin
          b_d = b_q;
        end
      end
      ST_READY: begin
        if (press_s) begin
          valid_d = 1'b0;
          neg_d   = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        valid_d = 1'b0;
        neg_d   = 1'b0;
      end
    endcase
  end

  // Operand output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= {OPW{1'b0}};
      b_q     <= {OPW{1'b0}};
      op_q    <= 1'b0;
      valid_q <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_op    = op_q;
  assign bus.out_valid = valid_q;
  assign bus.neg       = neg_q;
  assign bus.state_led = state_q;

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before a debounced level change is accepted (range 2..2^20).
REQ-002 clk_in  input  1  single system clock; all flops on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 sw  input  4  operand switches; asynchronous, sampled only at a capture edge.
REQ-005 op_sw  input  1  operation select; 0 = add, 1 = subtract.
REQ-006 btn  input  1  raw load pushbutton; active-high, asynchronous, bouncy.
REQ-007 out_a  output  4  registered operand A for the adder/subtractor stage.
REQ-008 out_b  output  4  registered operand B.
REQ-009 out_op  output  1  registered operation, captured together with B.
REQ-010 out_valid  output  1  high while out_a/out_b/out_op hold a complete operand set.
REQ-011 neg  output  1  result-negative flag for the display stage.
REQ-012 state_led  output  2  current FSM state encoding, for board LEDs.

Function
REQ-013 btn shall pass through a 2-flop synchronizer before any other logic.
REQ-014 Debounced level shall change only after the synchronized btn has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-015 A press shall be a one-cycle pulse on a debounced 0->1 transition; holding btn shall produce no further pulses, and the release shall produce none.
REQ-016 Press latency: the pulse shall assert 2 + DEBOUNCE_CYCLES cycles after btn goes high and stays stable.
REQ-017 FSM states: ENTER_A (state_led=00), ENTER_B (01), READY (10); encoding 11 is unreachable and shall recover to ENTER_A on the next cycle.
REQ-018 ENTER_A + press: capture sw into out_a, clear out_valid, go to ENTER_B.
REQ-019 ENTER_B + press: capture sw into out_b and op_sw into out_op, go to READY; out_valid shall assert in the same cycle as the READY state.
REQ-020 READY + press: deassert out_valid, go to ENTER_A; out_a/out_b/out_op shall hold until overwritten.
REQ-021 With no press, state and all outputs shall hold; sw/op_sw changes shall have no effect.
REQ-022 neg shall be valid only when out_valid=1 and shall be 0 otherwise.

Reset
REQ-023 While rst_n=0: state ENTER_A, out_a=0, out_b=0, out_op=0, out_valid=0, neg=0, synchronizer flops, debounced level and debounce counter 0.
REQ-024 Reset asserted mid-debounce or mid-entry shall discard any partial press or operand; no press pulse shall be generated by reset release, even if btn is held high.

Configuration
REQ-025 Macro OPERAND_ENTRY_ORDER_EN defined: at the ENTER_B capture, if op_sw=1 and the A value is less than sw, out_a shall take sw, out_b shall take the A value, and neg shall be 1; otherwise no swap and neg=0.
REQ-026 Macro undefined: no comparison and no swap; neg shall be tied to 0.

Structure
REQ-027 Shared package: FSM state typedef/encodings and the 4-bit operand width constant.
REQ-028 One sub-module, btn_debounce (synchronizer, counter, press pulse), parameterized by DEBOUNCE_CYCLES; the FSM and operand registers are in operand_entry.

Verification (bench DEBOUNCE_CYCLES=4)
REQ-029 Reset, sw=5, clean btn pulse of 10 cycles, then sw=3, op_sw=0, pulse -> out_a=5, out_b=3, out_op=0, out_valid=1, state_led=10, pulse asserted 6 cycles after btn rise.
REQ-030 btn toggling every 2 cycles for 20 cycles, then steady high -> exactly one press, taken only after 4 stable synchronized cycles.
REQ-031 btn held high for 100 cycles in ENTER_A -> one transition to ENTER_B only; release -> no change.
REQ-032 With OPERAND_ENTRY_ORDER_EN: A=2, B=7, op_sw=1 -> out_a=7, out_b=2, neg=1; without: out_a=2, out_b=7, neg=0.
REQ-033 rst_n pulsed low in ENTER_B with btn held high -> all outputs 0, state ENTER_A, no press after release until btn falls and rises again.
REQ-034 READY + press -> out_valid=0, state_led=00, out_a/out_b unchanged.
